// File: rtl/axi4_sram_bridge.sv
// SRAM-style requestor to AXI4 master bridge: one transaction outstanding,
// independent AW/W handshakes, registered read data and error status.
module axi4_sram_bridge #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter int         ID_W    = 1,
    parameter int         ID_VAL  = 0,
    parameter logic [3:0] AXCACHE = 4'b0011,
    parameter logic [2:0] AXPROT  = 3'b000
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // write address
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic [3:0]          AWQOS,
    output logic [3:0]          AWREGION,
    output logic                AWUSER,
    output logic                AWVALID,
    input  logic                AWREADY,
    // write data
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WUSER,
    output logic                WVALID,
    input  logic                WREADY,
    // write response
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BUSER,
    input  logic                BVALID,
    output logic                BREADY,
    // read address
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic [3:0]          ARQOS,
    output logic [3:0]          ARREGION,
    output logic                ARUSER,
    output logic                ARVALID,
    input  logic                ARREADY,
    // read data
    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RUSER,
    input  logic                RVALID,
    output logic                RREADY,
    // SRAM-style requestor
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_c_en,
    input  logic                mem_w_en,
    input  logic [DATA_W/8-1:0] mem_b_en,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_error,
    output logic                mem_stall
);
    localparam int               STRB_W = DATA_W / 8;
    localparam int               OFF    = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'((1 << OFF) - 1);
    localparam logic [ID_W-1:0]  ID_C   = ID_W'(ID_VAL);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                aw_done, w_done;
    logic                aw_fire, w_fire;

    assign aw_fire = AWVALID & AWREADY;
    assign w_fire  = WVALID & WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // All VALID/READY outputs decode from registered state only, so none
    // of them can depend combinationally on a READY input.
    always_comb begin
        state_nxt = state;
        ARVALID   = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        RREADY    = 1'b0;
        BREADY    = 1'b0;
        case (state)
            IDLE:    if (mem_c_en) state_nxt = mem_w_en ? WR_REQ : RD_ADDR;
            RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) state_nxt = DONE;
            end
            WR_REQ: begin
                AWVALID = ~aw_done;
                WVALID  = ~w_done;
                if ((aw_done | aw_fire) & (w_done | w_fire)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else begin
            if (state == IDLE && mem_c_en) begin
                addr_q  <= mem_addr & ALIGN;
                wdata_q <= mem_wdata;
                strb_q  <= mem_b_en;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_REQ) begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
            if (state == RD_DATA && RVALID) begin
                mem_rdata <= RDATA;
                mem_error <= RRESP[1] | ~RLAST | (RID != ID_C);
            end
            if (state == WR_RESP && BVALID)
                mem_error <= BRESP[1] | (BID != ID_C);
        end
    end

    assign mem_stall = mem_c_en & (state != DONE);

    assign AWID     = ID_C;
    assign AWADDR   = addr_q;
    assign AWLEN    = 8'd0;
    assign AWSIZE   = 3'(OFF);
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = AXCACHE;
    assign AWPROT   = AXPROT;
    assign AWQOS    = 4'd0;
    assign AWREGION = 4'd0;
    assign AWUSER   = 1'b0;

    assign WDATA = wdata_q;
    assign WSTRB = strb_q;
    assign WLAST = WVALID;
    assign WUSER = 1'b0;

    assign ARID     = ID_C;
    assign ARADDR   = addr_q;
    assign ARLEN    = 8'd0;
    assign ARSIZE   = 3'(OFF);
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = AXCACHE;
    assign ARPROT   = AXPROT;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;
    assign ARUSER   = 1'b0;

    // User sideband on responses carries nothing for this bridge.
    logic unused_user;
    assign unused_user = BUSER ^ RUSER;
endmodule

// File: tb/tb_axi4_sram_bridge.sv
// Randomized bench for axi4_sram_bridge: a cycle-driven AXI slave with random
// ready/valid delays, checked against a transaction-level expectation model.
module tb_axi4_sram_bridge;
    logic        ACLK, ARESET;
    logic [0:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  AWCACHE, ARCACHE, AWQOS, ARQOS, AWREGION, ARREGION, WSTRB;
    logic        AWLOCK, ARLOCK, AWUSER, ARUSER, WLAST, WUSER, BUSER, RUSER, RLAST;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_c_en, mem_w_en, mem_error, mem_stall;
    logic [3:0]  mem_b_en;

    // 64-bit data build
    logic [0:0]  d64_awid, d64_arid, d64_bid, d64_rid;
    logic [31:0] d64_awaddr, d64_araddr, d64_addr;
    logic [63:0] d64_wdata, d64_rdata_in, d64_mwdata, d64_mrdata;
    logic [7:0]  d64_awlen, d64_arlen, d64_wstrb, d64_ben;
    logic [2:0]  d64_awsize, d64_arsize, d64_awprot, d64_arprot;
    logic [1:0]  d64_awburst, d64_arburst, d64_bresp, d64_rresp;
    logic [3:0]  d64_awcache, d64_arcache, d64_awqos, d64_arqos, d64_awregion, d64_arregion;
    logic        d64_awlock, d64_arlock, d64_awuser, d64_aruser, d64_wlast, d64_wuser;
    logic        d64_awvalid, d64_awready, d64_wvalid, d64_wready, d64_bvalid, d64_bready;
    logic        d64_arvalid, d64_arready, d64_rvalid, d64_rready, d64_rlast;
    logic        d64_cen, d64_wen, d64_err, d64_stall;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] model_rdata;

    axi4_sram_bridge dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .AWREGION(AWREGION), .AWUSER(AWUSER), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en),
        .mem_w_en(mem_w_en), .mem_b_en(mem_b_en), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_stall(mem_stall)
    );

    axi4_sram_bridge #(.DATA_W(64)) dut64 (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(d64_awid), .AWADDR(d64_awaddr), .AWLEN(d64_awlen), .AWSIZE(d64_awsize),
        .AWBURST(d64_awburst), .AWLOCK(d64_awlock), .AWCACHE(d64_awcache),
        .AWPROT(d64_awprot), .AWQOS(d64_awqos), .AWREGION(d64_awregion),
        .AWUSER(d64_awuser), .AWVALID(d64_awvalid), .AWREADY(d64_awready),
        .WDATA(d64_wdata), .WSTRB(d64_wstrb), .WLAST(d64_wlast), .WUSER(d64_wuser),
        .WVALID(d64_wvalid), .WREADY(d64_wready),
        .BID(d64_bid), .BRESP(d64_bresp), .BUSER(1'b0), .BVALID(d64_bvalid),
        .BREADY(d64_bready),
        .ARID(d64_arid), .ARADDR(d64_araddr), .ARLEN(d64_arlen), .ARSIZE(d64_arsize),
        .ARBURST(d64_arburst), .ARLOCK(d64_arlock), .ARCACHE(d64_arcache),
        .ARPROT(d64_arprot), .ARQOS(d64_arqos), .ARREGION(d64_arregion),
        .ARUSER(d64_aruser), .ARVALID(d64_arvalid), .ARREADY(d64_arready),
        .RID(d64_rid), .RDATA(d64_rdata_in), .RRESP(d64_rresp), .RLAST(d64_rlast),
        .RUSER(1'b0), .RVALID(d64_rvalid), .RREADY(d64_rready),
        .mem_addr(d64_addr), .mem_wdata(d64_mwdata), .mem_c_en(d64_cen),
        .mem_w_en(d64_wen), .mem_b_en(d64_ben), .mem_rdata(d64_mrdata),
        .mem_error(d64_err), .mem_stall(d64_stall)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_cycle();
        mem_c_en = 1'b0;
        tick();
    endtask

    // One transaction against a slave whose per-channel delays are given.
    // Expectations come from the request and the response the slave returns.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] ben, input int d_ar, input int d_r,
                           input int d_aw, input int d_w, input int d_b,
                           input logic [1:0] resp, input logic id_bad, input logic last,
                           input logic [31:0] rdata, input bit b2b, input bit check_lat);
        int          cyc, first_v, c_ar, c_r, c_aw, c_w, c_b;
        bit          ar_done, aw_done, w_done, rsp_done, fin;
        bit          ar_p, aw_p, w_p, rsp_p;
        logic [31:0] exp_addr, exp_rdata;
        logic        exp_err;
        exp_addr  = addr & ~32'h3;
        exp_rdata = wr ? model_rdata : rdata;
        exp_err   = wr ? (resp[1] | id_bad) : (resp[1] | ~last | id_bad);
        mem_c_en = 1'b1; mem_w_en = wr; mem_addr = addr; mem_wdata = wdata; mem_b_en = ben;
        RDATA = rdata; RRESP = resp; RLAST = last; RID = id_bad; BRESP = resp; BID = id_bad;
        cyc = 0; first_v = -1; c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
        ar_done = 0; aw_done = 0; w_done = 0; rsp_done = 0; fin = 0;
        ar_p = 0; aw_p = 0; w_p = 0; rsp_p = 0;
        while (!fin && cyc < 200) begin
            tick();
            cyc++;
            if (ar_p) ar_done = 1;
            if (aw_p) aw_done = 1;
            if (w_p) w_done = 1;
            if (rsp_p) rsp_done = 1;
            if (!mem_stall) begin
                fin = 1;
            end else begin
                if (first_v < 0 && (ARVALID || AWVALID || WVALID)) first_v = cyc;
                chk("ar_illegal", ARVALID & (wr | ar_done), 0);
                chk("aw_illegal", AWVALID & (!wr | aw_done), 0);
                chk("w_illegal", WVALID & (!wr | w_done), 0);
                chk("rready_illegal", RREADY & (wr | !ar_done), 0);
                chk("bready_illegal", BREADY & (!wr | !(aw_done & w_done)), 0);
                chk("wlast", WLAST, WVALID);
                if (ARVALID) chk("araddr", ARADDR, exp_addr);
                if (AWVALID) chk("awaddr", AWADDR, exp_addr);
                if (WVALID) begin
                    chk("wdata", WDATA, wdata);
                    chk("wstrb", WSTRB, ben);
                end
                ARREADY = ARVALID && (c_ar >= d_ar);
                if (ARVALID) c_ar++;
                AWREADY = AWVALID && (c_aw >= d_aw);
                if (AWVALID) c_aw++;
                WREADY = WVALID && (c_w >= d_w);
                if (WVALID) c_w++;
                RVALID = !wr && ar_done && !rsp_done && (c_r >= d_r);
                if (!wr && ar_done) c_r++;
                BVALID = wr && aw_done && w_done && !rsp_done && (c_b >= d_b);
                if (wr && aw_done && w_done) c_b++;
                ar_p  = ARVALID && ARREADY;
                aw_p  = AWVALID && AWREADY;
                w_p   = WVALID && WREADY;
                rsp_p = (RVALID && RREADY) || (BVALID && BREADY);
            end
        end
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        chk("timeout", fin, 1);
        chk("resp_seen", rsp_done, 1);
        chk("mem_rdata", mem_rdata, exp_rdata);
        chk("mem_error", mem_error, exp_err);
        if (check_lat) begin
            chk("latency", cyc, 3 + b2b);
            chk("first_valid", first_v, 1 + b2b);
        end
        if (!wr) model_rdata = rdata;
    endtask

    initial begin
        ARESET = 1; mem_c_en = 0; mem_w_en = 0; mem_addr = 0; mem_wdata = 0; mem_b_en = 0;
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        RDATA = 0; RRESP = 0; RLAST = 1; RID = 0; BRESP = 0; BID = 0; BUSER = 0; RUSER = 0;
        d64_cen = 0; d64_wen = 0; d64_addr = 0; d64_mwdata = 0; d64_ben = 0;
        d64_arready = 0; d64_awready = 0; d64_wready = 0; d64_rvalid = 0; d64_bvalid = 0;
        d64_rdata_in = 0; d64_rresp = 0; d64_rlast = 1; d64_rid = 0; d64_bresp = 0; d64_bid = 0;
        model_rdata = 0;
        tick(); tick();
        ARESET = 0;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_error", mem_error, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("arsize", ARSIZE, 2);
        chk("awsize", AWSIZE, 2);
        chk("arlen", ARLEN, 0);
        chk("arburst", ARBURST, 1);
        chk("awcache", AWCACHE, 4'b0011);
        chk("arprot", ARPROT, 0);
        chk("awid", AWID, 0);

        // directed cases from the plan
        run_txn(0, 32'h0000_1006, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'hDEADBEEF, 0, 1);
        idle_cycle();
        run_txn(1, 32'h0000_2000, 32'h12345678, 4'b0011, 0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        idle_cycle();
        run_txn(0, 32'h0000_3000, 0, 0, 1, 1, 0, 0, 0, 2'b10, 0, 1, 32'h0BAD0BAD, 0, 0);
        idle_cycle();
        run_txn(0, 32'h0000_3004, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'h600DF00D, 0, 1);
        idle_cycle();
        run_txn(1, 32'h0000_4008, 32'hA5A5A5A5, 4'b1111, 0, 0, 0, 0, 0, 2'b11, 0, 1, 0, 0, 1);
        run_txn(0, 32'h0000_400C, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 32'h13579BDF, 1, 1);
        idle_cycle();

        // reset while waiting for read data
        mem_c_en = 1; mem_w_en = 0; mem_addr = 32'h0000_5000;
        tick();
        ARREADY = 1;
        tick();
        ARREADY = 0;
        chk("rready_before_rst", RREADY, 1);
        ARESET = 1;
        tick();
        ARESET = 0;
        model_rdata = 0;
        chk("midrst_arvalid", ARVALID, 0);
        chk("midrst_rready", RREADY, 0);
        chk("midrst_stall", mem_stall, mem_c_en);
        chk("midrst_rdata", mem_rdata, 0);
        chk("midrst_error", mem_error, 0);
        run_txn(0, 32'h0000_5010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'h2468ACE0, 0, 1);
        idle_cycle();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit         wr, zero, b2b;
            int         dar, dr, daw, dw, db;
            logic [1:0] rsp;
            wr   = $urandom_range(0, 1);
            zero = ($urandom_range(0, 3) == 0);
            b2b  = (i > 0) && ($urandom_range(0, 3) == 0);
            dar = zero ? 0 : $urandom_range(0, 3);
            dr  = zero ? 0 : $urandom_range(0, 3);
            daw = zero ? 0 : $urandom_range(0, 3);
            dw  = zero ? 0 : $urandom_range(0, 3);
            db  = zero ? 0 : $urandom_range(0, 3);
            rsp = 2'($urandom_range(0, 3));
            if (!b2b) idle_cycle();
            run_txn(wr, $urandom, $urandom, 4'($urandom_range(0, 15)), dar, dr, daw, dw, db,
                    rsp, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                    $urandom, b2b, zero);
        end
        idle_cycle();

        // 64-bit build: read
        d64_cen = 1; d64_wen = 0; d64_addr = 32'h0000_200C;
        tick();
        chk("d64_arvalid", d64_arvalid, 1);
        chk("d64_araddr", d64_araddr, 32'h0000_2008);
        chk("d64_arsize", d64_arsize, 3);
        d64_arready = 1;
        tick();
        d64_arready = 0;
        chk("d64_rready", d64_rready, 1);
        d64_rvalid = 1; d64_rdata_in = 64'hCAFEF00D_12345678;
        tick();
        d64_rvalid = 0;
        chk("d64_stall", d64_stall, 0);
        chk("d64_rdata", d64_mrdata, 64'hCAFEF00D_12345678);
        chk("d64_rerr", d64_err, 0);
        d64_cen = 0;
        tick();
        // 64-bit build: write
        d64_cen = 1; d64_wen = 1; d64_addr = 32'h0000_3010;
        d64_mwdata = 64'h01234567_89ABCDEF; d64_ben = 8'hA5;
        tick();
        chk("d64_awvalid", d64_awvalid, 1);
        chk("d64_wvalid", d64_wvalid, 1);
        chk("d64_wstrb", d64_wstrb, 8'hA5);
        chk("d64_wdata", d64_wdata, 64'h01234567_89ABCDEF);
        d64_awready = 1; d64_wready = 1;
        tick();
        d64_awready = 0; d64_wready = 0;
        chk("d64_bready", d64_bready, 1);
        d64_bvalid = 1;
        tick();
        d64_bvalid = 0;
        chk("d64_wstall", d64_stall, 0);
        chk("d64_werr", d64_err, 0);
        chk("d64_rdata_keep", d64_mrdata, 64'hCAFEF00D_12345678);
        d64_cen = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
